// File: rtl/mul16_seq.sv
// -----------------------------------------------------------------------------
// mul16_seq -- 16x16 unsigned sequential multiplier (radix-2 shift-add)
//
// One multiply takes 16 RUN cycles followed by a single DONE cycle. The
// partial product lives in a 32-bit accumulator. The multiplier occupies the
// lower half and is shifted out one bit per cycle. The running sum occupies
// the upper half and is extended by a 16-bit adder whose carry-out is kept.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous, active-high reset
//   start    in   1   begin a multiply (only looked at in IDLE)
//   a        in  16   unsigned multiplicand, captured on the accepting edge
//   b        in  16   unsigned multiplier,   captured on the accepting edge
//   busy     out  1   high while in RUN
//   done     out  1   one-cycle pulse in DONE; product valid from this cycle
//   product  out 32   registered a*b, held until the next completion
// -----------------------------------------------------------------------------
module mul16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] acc;
    logic [15:0] mcand;
    logic [3:0]  cnt;

    logic [16:0] add_sum;
    logic [16:0] upper_next;
    logic [31:0] acc_next;

    // One shift-add step. The 17-bit upper value keeps the adder's carry-out
    // so the product is exact, e.g. 0xFFFF*0xFFFF = 0xFFFE0001.
    assign add_sum    = {1'b0, acc[31:16]} + {1'b0, mcand};
    assign upper_next = acc[0] ? add_sum : {1'b0, acc[31:16]};
    assign acc_next   = {upper_next, acc[15:1]};

    // State register.
    // NOTE: clocked state uses non-blocking (<=) assignments so that every
    // register samples the values from before the edge, independent of the
    // order in which the always_ff blocks run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case statement. Otherwise
    // any path that does not assign it would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. product is written only on the RUN->DONE edge, so a
    // partial sum never appears on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= 32'h0;
            mcand   <= 16'h0;
            cnt     <= 4'h0;
            product <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        acc   <= {16'h0, b};
                        cnt   <= 4'h0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        product <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
